calc_ctrl: RTL and testbench
============================

# calc_ctrl

Calculator sequencing controller between the keypad scanner and an external multi-cycle arithmetic unit. It consumes one-cycle key events, assembles two decimal operands, latches the operator, and starts the ALU on '='. It collects the ALU result and drives the display value, sign and error outputs. It owns all calculator state; the ALU and the display driver are stateless with respect to entry.

## Interface
- DIGITS, 4: maximum decimal digits per operand; MAX_VAL = 10^DIGITS − 1.
- W, 16: operand width in bits; must hold MAX_VAL.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- key_valid  in  1  one-cycle pulse per debounced key press.
- key_code  in  4  key value, valid with key_valid. 0–9 are digits; 10 '+', 11 '−', 12 '×', 13 '÷', 14 '=', 15 'C'.
- alu_start  out  1  one-cycle start pulse.
- alu_op  out  2  operation: 00 add, 01 sub, 10 mul, 11 div (truncating). Stable from start until done.
- alu_a, alu_b  out  W  operands, stable from start until done.
- alu_done  in  1  one-cycle pulse; the result is valid in the same cycle.
- alu_result  in  2W  two's-complement signed result.
- alu_err  in  1  divide-by-zero, valid with alu_done.
- disp_value  out  W  unsigned magnitude to display.
- disp_neg  out  1  display minus sign.
- disp_err  out  1  error indicator.
- busy  out  1  high in EXEC.

## Operation
- States: ENTER_A, ENTER_B, EXEC, SHOW, ERR.
- **Reset state:** state ENTER_A; A, B and the digit count are 0; op = add. All outputs are 0.
- **Digit entry (ENTER_A / ENTER_B):**
  - The current operand becomes operand×10 + d, computed as (x<<3)+(x<<1)+d in W bits.
  - The digit count increments only if the operand was nonzero before the key, or d ≠ 0. Leading zeros do not count.
  - A digit is dropped if the count equals DIGITS.
  - disp_value follows the operand being entered; disp_neg = 0.
- **ENTER_A:**
  - Operator key: latch op, clear B and the count, go to ENTER_B. The display keeps A.
  - '=' is ignored.
- **ENTER_B:**
  - Operator key with no B digit pressed yet: replace op.
  - Operator key otherwise: see Configuration.
  - '=': go to EXEC. An empty B counts as 0.
- **EXEC:**
  - alu_start pulses on the first cycle; alu_a = A, alu_b = B.
  - Digit, operator and '=' keys are dropped.
  - 'C' sets a pending-clear flag, which is applied when alu_done arrives; the result is then discarded.
- **On alu_done:**
  - If alu_err = 1, or |alu_result| > MAX_VAL: go to ERR; disp_err = 1, disp_value = 0.
  - Otherwise go to SHOW; disp_value = |result|[W−1:0], disp_neg = result sign.
- **SHOW:**
  - Digit d: A = d, count = (d ≠ 0), disp_neg = 0, go to ENTER_A.
  - Operator key: see Configuration.
  - '=' is ignored.
- **ERR:** only 'C' is accepted; all other keys are dropped.
- **'C' in any state except EXEC:** immediate return to the reset state on the next cycle. disp_err clears.

## Timing
- Key to register or display update: 1 cycle after the key_valid cycle.
- '=' key at cycle t: state is EXEC and alu_start = 1 at t+1. alu_start is never asserted for more than one cycle.
- alu_done at cycle t: display outputs and state are updated at t+1.
- A key_valid arriving on the same cycle as alu_done is dropped.
- Any alu_done outside EXEC is ignored.
- Two consecutive key_valid cycles are each processed in order. There is no buffering beyond one key per cycle.
- rst_n assertion mid-EXEC returns all outputs to reset values asynchronously. A later alu_done is ignored.

## Configuration
- CALC_CHAIN_EN defined:
  - Operator in SHOW with a non-negative result: A = result, latch op, go to ENTER_B.
  - Operator in ENTER_B after a B digit: execute the pending op. On completion, A = result, op = new op, and the state becomes ENTER_B instead of SHOW. A negative or error result goes to SHOW or ERR as normal.
- CALC_CHAIN_EN undefined: those operator keys are dropped.

## Structure
- The shared package calc_pkg holds:
  - key-code constants (KEY_ADD..KEY_CLR);
  - the alu_op encodings;
  - the state enum;
  - the MAX_VAL function of DIGITS.
- One sub-module, calc_operand_acc, holds the operand register and digit counter. Its inputs are load-digit, clear and set-value; it is instantiated once and steered between A and B.

## Test plan
- Keys 1,2,'+',3,4,'=' with the ALU returning 46 after 5 cycles: alu_a=12, alu_b=34, alu_op=00, one alu_start pulse; disp_value=46, disp_neg=0.
- Keys 0,0,9,9,9,9,9 (DIGITS=4): A=9999, the fifth 9 is dropped, disp_value=9999.
- Keys 3,'−',5,'=' with result −2: disp_value=2, disp_neg=1. A following '+' is dropped in SHOW.
- Keys 7,'÷',0,'=' with alu_err=1: disp_err=1, state ERR. Digit 5 is ignored; 'C' clears disp_err and disp_value to 0.
- 'C' pressed 2 cycles after alu_start, then alu_done: state ENTER_A, disp_value=0, and no second alu_start.
- With CALC_CHAIN_EN, keys 2,'+',3,'+' (result 5), then 4,'=': the second run has alu_a=5, alu_b=4, and the display shows 9.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencing controller: key codes,
// ALU operation encodings, controller states and the operand range limit.
// Optional feature macro used by calc_ctrl: CALC_CHAIN_EN (operator chaining).
package calc_pkg;

  localparam int DIGITS = 4;
  localparam int W      = 16;
  localparam int CNT_W  = $clog2(DIGITS + 1);

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_EQ  = 4'd14;
  localparam logic [3:0] KEY_CLR = 4'd15;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    ST_ENTER_A = 3'd0,
    ST_ENTER_B = 3'd1,
    ST_EXEC    = 3'd2,
    ST_SHOW    = 3'd3,
    ST_ERR     = 3'd4
  } calc_state_e;

  // Largest value representable with the given number of decimal digits.
  function automatic int unsigned max_val(input int digits);
    int unsigned v;
    v = 1;
    for (int i = 0; i < digits; i++) v = v * 10;
    return v - 1;
  endfunction

  localparam int unsigned MAX_VAL = max_val(DIGITS);

  // Map an operator key code onto the ALU operation encoding.
  function automatic logic [1:0] key_to_op(input logic [3:0] k);
    logic [1:0] op;
    case (k)
      KEY_SUB: op = OP_SUB;
      KEY_MUL: op = OP_MUL;
      KEY_DIV: op = OP_DIV;
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/calc_operand_acc.sv
// Decimal operand accumulator: holds the operand currently being typed and
// its count of significant digits. Leading zeros do not count, and digits
// beyond DIGITS are dropped. set_value loads a single-digit value directly.
module calc_operand_acc import calc_pkg::*; (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_digit,
  input  logic [3:0]   digit,
  input  logic         clear,
  input  logic         set_value,
  input  logic [W-1:0] set_val,
  output logic [W-1:0] value
);

  logic [CNT_W-1:0] count;
  logic [W-1:0]     value_x10;

  // x*10 as shift-and-add so no multiplier is implied.
  assign value_x10 = (value << 3) + (value << 1);

  // Operand and digit-count register; clear beats set beats digit entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
      count <= '0;
    end else if (clear) begin
      value <= '0;
      count <= '0;
    end else if (set_value) begin
      value <= set_val;
      count <= (set_val != '0) ? CNT_W'(1) : '0;
    end else if (load_digit && (count != CNT_W'(DIGITS))) begin
      value <= value_x10 + {{(W-4){1'b0}}, digit};
      if ((value != '0) || (digit != 4'd0)) count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/calc_ctrl.sv
// Calculator sequencing controller. Assembles two decimal operands from key
// events, starts an external multi-cycle ALU on '=', and drives the display.
// Optional feature: define CALC_CHAIN_EN to let an operator key after a
// complete expression (or in SHOW) continue the calculation from the result.
//
// Handshakes: key_valid is a one-cycle event with key_code valid alongside it
// and no back-pressure (keys arriving when they cannot be used are dropped).
// alu_start is a one-cycle request; alu_op/alu_a/alu_b hold until alu_done,
// a one-cycle response carrying alu_result/alu_err in the same cycle.
module calc_ctrl import calc_pkg::*; (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           key_valid,
  input  logic [3:0]     key_code,
  output logic           alu_start,
  output logic [1:0]     alu_op,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  input  logic           alu_done,
  input  logic [2*W-1:0] alu_result,
  input  logic           alu_err,
  output logic [W-1:0]   disp_value,
  output logic           disp_neg,
  output logic           disp_err,
  output logic           busy,
  output logic [2:0]     dbg_state
);

  calc_state_e state, state_n;

  logic [W-1:0] a_reg, a_val, acc_value, res_mag;
  logic [1:0]   op_reg, op_val;
  logic         res_neg, b_seen, clr_pend, started;

  logic acc_load, acc_clear, acc_set, a_ld, op_ld, b_digit;
  logic clr_all, clr_pend_set, res_ld;

`ifdef CALC_CHAIN_EN
  logic       chain_pend, exec_enter, chain_arm;
  logic [1:0] next_op;
`endif

  logic is_digit, is_op, is_eq, is_clr;
  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_op    = key_valid && (key_code >= KEY_ADD) && (key_code <= KEY_DIV);
  assign is_eq    = key_valid && (key_code == KEY_EQ);
  assign is_clr   = key_valid && (key_code == KEY_CLR);

  // Result magnitude and sign; a magnitude above MAX_VAL is a display error.
  logic [2*W-1:0] res_abs;
  logic           res_sign, res_bad;
  assign res_sign = alu_result[2*W-1];
  assign res_abs  = res_sign ? (~alu_result + 1'b1) : alu_result;
  assign res_bad  = alu_err || (res_abs > (2*W)'(MAX_VAL));

  // Single accumulator, steered: it holds A in ENTER_A and B afterwards.
  calc_operand_acc u_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_digit (acc_load),
    .digit      (key_code),
    .clear      (acc_clear || clr_all),
    .set_value  (acc_set),
    .set_val    ({{(W-4){1'b0}}, key_code}),
    .value      (acc_value)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_ENTER_A;
    else        state <= state_n;
  end

  // Next-state and datapath-strobe decode from the current key / ALU event.
  always_comb begin
    state_n      = state;
    acc_load     = 1'b0;
    acc_clear    = 1'b0;
    acc_set      = 1'b0;
    a_ld         = 1'b0;
    a_val        = acc_value;
    op_ld        = 1'b0;
    op_val       = key_to_op(key_code);
    b_digit      = 1'b0;
    clr_all      = 1'b0;
    clr_pend_set = 1'b0;
    res_ld       = 1'b0;
`ifdef CALC_CHAIN_EN
    exec_enter   = 1'b0;
    chain_arm    = 1'b0;
`endif
    case (state)
      ST_ENTER_A: begin
        if (is_digit) acc_load = 1'b1;
        else if (is_op) begin
          a_ld      = 1'b1;
          op_ld     = 1'b1;
          acc_clear = 1'b1;
          state_n   = ST_ENTER_B;
        end else if (is_clr) clr_all = 1'b1;
      end
      ST_ENTER_B: begin
        if (is_digit) begin
          acc_load = 1'b1;
          b_digit  = 1'b1;
        end else if (is_op) begin
          if (!b_seen) op_ld = 1'b1;
`ifdef CALC_CHAIN_EN
          else begin
            exec_enter = 1'b1;
            chain_arm  = 1'b1;
            state_n    = ST_EXEC;
          end
`endif
        end else if (is_eq) begin
`ifdef CALC_CHAIN_EN
          exec_enter = 1'b1;
`endif
          state_n = ST_EXEC;
        end else if (is_clr) clr_all = 1'b1;
      end
      ST_EXEC: begin
        if (alu_done) begin
          if (clr_pend) clr_all = 1'b1;
          else if (res_bad) state_n = ST_ERR;
`ifdef CALC_CHAIN_EN
          else if (chain_pend && !res_sign) begin
            a_ld      = 1'b1;
            a_val     = res_abs[W-1:0];
            op_ld     = 1'b1;
            op_val    = next_op;
            acc_clear = 1'b1;
            state_n   = ST_ENTER_B;
          end
`endif
          else begin
            res_ld  = 1'b1;
            state_n = ST_SHOW;
          end
        end else if (is_clr) clr_pend_set = 1'b1;
      end
      ST_SHOW: begin
        if (is_digit) begin
          acc_set = 1'b1;
          state_n = ST_ENTER_A;
        end
`ifdef CALC_CHAIN_EN
        else if (is_op && !res_neg) begin
          a_ld      = 1'b1;
          a_val     = res_mag;
          op_ld     = 1'b1;
          acc_clear = 1'b1;
          state_n   = ST_ENTER_B;
        end
`endif
        else if (is_clr) clr_all = 1'b1;
      end
      ST_ERR: begin
        if (is_clr) clr_all = 1'b1;
      end
      default: clr_all = 1'b1;
    endcase
    if (clr_all) state_n = ST_ENTER_A;
  end

  // Operand A, operator, result and bookkeeping flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      op_reg   <= OP_ADD;
      res_mag  <= '0;
      res_neg  <= 1'b0;
      b_seen   <= 1'b0;
      clr_pend <= 1'b0;
      started  <= 1'b0;
`ifdef CALC_CHAIN_EN
      chain_pend <= 1'b0;
      next_op    <= OP_ADD;
`endif
    end else begin
      started <= (state == ST_EXEC);
      if (clr_all) begin
        a_reg    <= '0;
        op_reg   <= OP_ADD;
        res_mag  <= '0;
        res_neg  <= 1'b0;
        b_seen   <= 1'b0;
        clr_pend <= 1'b0;
`ifdef CALC_CHAIN_EN
        chain_pend <= 1'b0;
`endif
      end else begin
        if (a_ld)  a_reg  <= a_val;
        if (op_ld) op_reg <= op_val;
        if (acc_clear)    b_seen <= 1'b0;
        else if (b_digit) b_seen <= 1'b1;
        if (res_ld) begin
          res_mag <= res_abs[W-1:0];
          res_neg <= res_sign;
        end
        if (clr_pend_set)           clr_pend <= 1'b1;
        else if (state != ST_EXEC)  clr_pend <= 1'b0;
`ifdef CALC_CHAIN_EN
        if (exec_enter) begin
          chain_pend <= chain_arm;
          if (chain_arm) next_op <= key_to_op(key_code);
        end
`endif
      end
    end
  end

  // Outputs: ALU request while executing, display chosen by state.
  always_comb begin
    busy       = (state == ST_EXEC);
    alu_start  = busy && !started;
    alu_op     = op_reg;
    alu_a      = busy ? a_reg : '0;
    alu_b      = busy ? acc_value : '0;
    disp_value = '0;
    disp_neg   = 1'b0;
    disp_err   = 1'b0;
    case (state)
      ST_ENTER_A: disp_value = acc_value;
      ST_ENTER_B,
      ST_EXEC:    disp_value = b_seen ? acc_value : a_reg;
      ST_SHOW: begin
        disp_value = res_mag;
        disp_neg   = res_neg;
      end
      ST_ERR:     disp_err = 1'b1;
      default:    disp_value = '0;
    endcase
    dbg_state = state;
  end

endmodule

// File: tb/tb_calc_ctrl.sv
// Testbench for calc_ctrl: directed key sequences, a bench-side ALU, an
// integer-level behavioural model checked every cycle, and literal checks.
module tb_calc_ctrl;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           key_valid = 1'b0;
  logic [3:0]     key_code = 4'd0;
  logic           alu_done = 1'b0;
  logic [2*W-1:0] alu_result = '0;
  logic           alu_err = 1'b0;
  logic           alu_start, busy, disp_neg, disp_err;
  logic [1:0]     alu_op;
  logic [W-1:0]   alu_a, alu_b, disp_value;
  logic [2:0]     dbg_state;

  calc_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .alu_start  (alu_start),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .alu_err    (alu_err),
    .disp_value (disp_value),
    .disp_neg   (disp_neg),
    .disp_err   (disp_err),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  int total = 0;
  int bad = 0;
  logic check_en = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // States: 0 ENTER_A, 1 ENTER_B, 2 EXEC, 3 SHOW, 4 ERR.
  int m_state = 0, m_a = 0, m_b = 0, m_op = 0, m_bseen = 0;
  int m_clrp = 0, m_chain = 0, m_nop = 0, m_res = 0, m_age = 0;
  int mk, mr, mmag;
  logic [33:0] exp_q[$];

  task automatic m_reset();
    m_state = 0; m_a = 0; m_b = 0; m_op = 0; m_bseen = 0;
    m_clrp = 0; m_chain = 0; m_nop = 0; m_res = 0; m_age = 0;
  endtask

  task automatic m_exec(input int chain, input int nop);
    exp_q.push_back({2'(m_op), 16'(m_a), 16'(m_b)});
    m_chain = chain;
    m_nop = nop;
    m_state = 2;
    m_age = 0;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else begin
        mk = int'(key_code);
        if (m_state == 2) m_age++;
        case (m_state)
          0: if (key_valid) begin
               if (mk <= 9) begin
                 if (m_a < 1000) m_a = m_a * 10 + mk;
               end else if (mk <= 13) begin
                 m_op = mk - 10; m_b = 0; m_bseen = 0; m_state = 1;
               end else if (mk == 15) m_reset();
             end
          1: if (key_valid) begin
               if (mk <= 9) begin
                 m_bseen = 1;
                 if (m_b < 1000) m_b = m_b * 10 + mk;
               end else if (mk <= 13) begin
                 if (m_bseen == 0) m_op = mk - 10;
`ifdef CALC_CHAIN_EN
                 else m_exec(1, mk - 10);
`endif
               end else if (mk == 14) m_exec(0, 0);
               else m_reset();
             end
          2: if (alu_done) begin
               mr = $signed(alu_result);
               mmag = (mr < 0) ? -mr : mr;
               if (m_clrp != 0) m_reset();
               else if (alu_err || mmag > 9999) m_state = 4;
               else if (m_chain != 0 && mr >= 0) begin
                 m_a = mr; m_op = m_nop; m_b = 0; m_bseen = 0; m_state = 1;
               end else begin
                 m_res = mr; m_state = 3;
               end
             end else if (key_valid && mk == 15) m_clrp = 1;
          3: if (key_valid) begin
               if (mk <= 9) begin
                 m_a = mk; m_state = 0;
               end
`ifdef CALC_CHAIN_EN
               else if (mk <= 13 && m_res >= 0) begin
                 m_a = m_res; m_op = mk - 10; m_b = 0; m_bseen = 0; m_state = 1;
               end
`endif
               else if (mk == 15) m_reset();
             end
          default: if (key_valid && mk == 15) m_reset();
        endcase
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        cmp("state", dbg_state, m_state);
        cmp("busy", busy, m_state == 2);
        cmp("alu_start", alu_start, (m_state == 2) && (m_age == 0));
        cmp("disp_err", disp_err, m_state == 4);
        if (m_state != 2) begin
          case (m_state)
            0: cmp("disp_value", disp_value, m_a);
            1: cmp("disp_value", disp_value, (m_bseen != 0) ? m_b : m_a);
            3: cmp("disp_value", disp_value, (m_res < 0) ? -m_res : m_res);
            default: cmp("disp_value", disp_value, 0);
          endcase
          cmp("disp_neg", disp_neg, (m_state == 3) && (m_res < 0));
        end
      end
    end
  end

  // ---------------- bench ALU ----------------
  int alu_lat = 5;
  int alu_cd = 0;
  int n_starts = 0;
  logic [15:0] last_a = '0, last_b = '0;
  logic [1:0]  last_op = '0;
  int pend_res = 0;
  logic pend_err = 1'b0;
  logic [33:0] e;

  initial begin
    forever begin
      @(negedge clk);
      alu_done = 1'b0;
      alu_err = 1'b0;
      if (alu_cd > 0) begin
        alu_cd--;
        if (alu_cd == 0) begin
          alu_done = 1'b1;
          alu_result = pend_res;
          alu_err = pend_err;
        end
      end
      if (rst_n && alu_start) begin
        n_starts++;
        last_a = alu_a; last_b = alu_b; last_op = alu_op;
        cmp("exec_queue_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          cmp("alu_op", alu_op, e[33:32]);
          cmp("alu_a", alu_a, e[31:16]);
          cmp("alu_b", alu_b, e[15:0]);
        end
        pend_err = 1'b0;
        case (alu_op)
          2'd0: pend_res = int'(alu_a) + int'(alu_b);
          2'd1: pend_res = int'(alu_a) - int'(alu_b);
          2'd2: pend_res = int'(alu_a) * int'(alu_b);
          default: begin
            if (alu_b == 0) begin pend_res = 0; pend_err = 1'b1; end
            else pend_res = int'(alu_a) / int'(alu_b);
          end
        endcase
        alu_cd = alu_lat;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic press(input int k);
    key_valid = 1'b1;
    key_code = 4'(k);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    key_code = 4'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic keys(input int ks[]);
    foreach (ks[i]) press(ks[i]);
  endtask

  // ---------------- directed sequence ----------------
  int s0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_en = 1'b1;
    cmp("reset_disp", disp_value, 0);
    cmp("reset_state", dbg_state, 0);
    cmp("reset_op", alu_op, 0);
    cmp("reset_start", alu_start, 0);

    // 12 + 34 = 46
    keys('{1, 2});
    cmp("a_entry", disp_value, 12);
    press(10);
    cmp("disp_keeps_a", disp_value, 12);
    keys('{3, 4});
    cmp("b_entry", disp_value, 34);
    s0 = n_starts;
    press(14);
    cmp("eq_busy", busy, 1);
    cmp("eq_start", alu_start, 1);
    idle(7);
    cmp("one_start", n_starts - s0, 1);
    cmp("add_a", last_a, 12);
    cmp("add_b", last_b, 34);
    cmp("add_op", last_op, 0);
    cmp("add_disp", disp_value, 46);
    cmp("add_neg", disp_neg, 0);
    cmp("add_state", dbg_state, 3);

    // leading zeros and the digit limit
    press(15);
    cmp("clr_state", dbg_state, 0);
    keys('{0, 0});
    cmp("zeros_disp", disp_value, 0);
    keys('{9, 9, 9, 9});
    cmp("four_nines", disp_value, 9999);
    press(9);
    cmp("fifth_dropped", disp_value, 9999);

    // 3 - 5 = -2, then '+' in SHOW, then digit in SHOW
    press(15);
    keys('{3, 11, 5, 14});
    idle(7);
    cmp("neg_disp", disp_value, 2);
    cmp("neg_sign", disp_neg, 1);
    press(10);
    cmp("op_in_show_neg", dbg_state, 3);
    press(5);
    cmp("show_digit_state", dbg_state, 0);
    cmp("show_digit_disp", disp_value, 5);
    cmp("show_digit_neg", disp_neg, 0);

    // 7 / 0 -> error
    press(15);
    keys('{7, 13, 0, 14});
    idle(7);
    cmp("div0_err", disp_err, 1);
    cmp("div0_state", dbg_state, 4);
    cmp("div0_disp", disp_value, 0);
    press(5);
    cmp("err_digit_dropped", dbg_state, 4);
    press(15);
    cmp("err_clr_err", disp_err, 0);
    cmp("err_clr_disp", disp_value, 0);

    // 'C' while executing
    keys('{8, 12, 6});
    s0 = n_starts;
    press(14);
    idle(1);
    press(15);
    idle(7);
    cmp("pend_clr_state", dbg_state, 0);
    cmp("pend_clr_disp", disp_value, 0);
    cmp("pend_clr_starts", n_starts - s0, 1);

    // asynchronous reset mid-EXEC; later alu_done is ignored
    keys('{1, 10, 1, 14});
    idle(2);
    rst_n = 1'b0;
    #2;
    cmp("areset_busy", busy, 0);
    cmp("areset_state", dbg_state, 0);
    cmp("areset_alu_a", alu_a, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(8);
    cmp("late_done_state", dbg_state, 0);
    cmp("late_done_disp", disp_value, 0);

    // '=' ignored in ENTER_A, operator replaced before any B digit
    press(9);
    press(14);
    cmp("eq_in_a", dbg_state, 0);
    keys('{10, 11, 12});
    cmp("op_replaced", alu_op, 2);
    keys('{3, 14});
    idle(7);
    cmp("mul_disp", disp_value, 27);
    cmp("mul_op", last_op, 2);

    // empty B counts as zero
    press(15);
    keys('{4, 11, 14});
    idle(7);
    cmp("empty_b", last_b, 0);
    cmp("empty_b_disp", disp_value, 4);

    // out-of-range product
    press(15);
    keys('{9, 9, 9, 9, 12, 9, 9, 9, 9, 14});
    idle(7);
    cmp("ovf_err", disp_err, 1);
    cmp("ovf_state", dbg_state, 4);

    // 2 + 3 + 4 =
    press(15);
    keys('{2, 10, 3, 10});
`ifdef CALC_CHAIN_EN
    idle(7);
    cmp("chain_state", dbg_state, 1);
    cmp("chain_disp", disp_value, 5);
    keys('{4, 14});
    idle(7);
    cmp("chain_a", last_a, 5);
    cmp("chain_b", last_b, 4);
    cmp("chain_result", disp_value, 9);
`else
    cmp("nochain_state", dbg_state, 1);
    keys('{4, 14});
    idle(7);
    cmp("nochain_a", last_a, 2);
    cmp("nochain_b", last_b, 34);
    cmp("nochain_result", disp_value, 36);
`endif

    // operator key in SHOW with a non-negative result
    keys('{12, 3, 14});
    idle(7);
`ifdef CALC_CHAIN_EN
    cmp("show_op_result", disp_value, 27);
`else
    cmp("show_op_dropped", disp_value, 3);
    cmp("show_op_state", dbg_state, 0);
`endif

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
